aes_job_scheduler: RTL and testbench

- Multi-requester front end for the AES-128 core (key expansion, encrypt and decrypt engines).
- Arbitrates round-robin among NUM_REQ requesters, each using a valid/ready job interface.
- Issues one job at a time to the core as a single-cycle command pulse, waits for the matching done, and returns the result tagged with the requester ID on a valid/ready response port.
- Tracks whether a key has been loaded, rejects illegal or premature jobs, and guards against a hung core with a timeout.

---
 rtl/aes_job_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_aes_job_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_scheduler.sv
// Round-robin job front end for the AES-128 core: one job in flight,
// key-loaded tracking, illegal-op rejection and a hung-core timeout.
module aes_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [2*NUM_REQ-1:0]   req_op_i,
    input  logic [128*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [127:0]           rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   key_valid_o,
    output logic                   aes_set_key_o,
    output logic                   aes_encrypt_o,
    output logic                   aes_decrypt_o,
    output logic [127:0]           aes_data_o,
    input  logic                   aes_set_key_enable_i,
    input  logic                   aes_gen_key_done_i,
    input  logic                   aes_encrypt_done_i,
    input  logic                   aes_decrypt_done_i,
    input  logic [127:0]           aes_ciphertext_i,
    input  logic [127:0]           aes_plaintext_i
);

    localparam logic [1:0] OP_KEY = 2'b00;
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] job_id;
    logic [1:0]      job_op;
    logic [127:0]    job_data;
    logic [127:0]    res_data;
    logic            res_err;
    logic            key_valid;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_next;

    logic            gnt_any;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   cand;
    logic [ID_W:0]   rr_inc;
    logic [ID_W-1:0] rr_next;
    logic [1:0]      gnt_op;
    logic [127:0]    gnt_data;
    logic            gnt_reject;
    logic            issue_fire;
    logic            done_match;
    logic [127:0]    done_data;

    // First valid requester at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!gnt_any && req_valid_i[cand[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_op   = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                gnt_op   = req_op_i[2*i +: 2];
                gnt_data = req_data_i[128*i +: 128];
            end
        end
    end

    always_comb begin
        rr_inc  = {1'b0, gnt_idx} + 1'b1;
        rr_next = (rr_inc >= NREQ) ? '0 : rr_inc[ID_W-1:0];
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_n && state == IDLE && gnt_any) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_idx == ID_W'(i)) begin
                    req_ready_o[i] = 1'b1;
                end
            end
        end
    end

    assign gnt_reject = (gnt_op == OP_ILL) ||
                        (gnt_op != OP_KEY && !key_valid);

    // Command pulses are decoded straight from the ISSUE state so they can
    // never appear elsewhere and can never overlap.
    assign aes_set_key_o = (state == ISSUE) && (job_op == OP_KEY) &&
                           aes_set_key_enable_i;
    assign aes_encrypt_o = (state == ISSUE) && (job_op == OP_ENC);
    assign aes_decrypt_o = (state == ISSUE) && (job_op == OP_DEC);
    assign issue_fire    = aes_set_key_o | aes_encrypt_o | aes_decrypt_o;

    always_comb begin
        done_match = 1'b0;
        done_data  = '0;
        unique case (job_op)
            OP_KEY: done_match = aes_gen_key_done_i;
            OP_ENC: begin
                done_match = aes_encrypt_done_i;
                done_data  = aes_ciphertext_i;
            end
            OP_DEC: begin
                done_match = aes_decrypt_done_i;
                done_data  = aes_plaintext_i;
            end
            default: done_match = 1'b0;
        endcase
    end

    assign tmo_next = tmo_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            job_id    <= '0;
            job_op    <= '0;
            job_data  <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            key_valid <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        job_id   <= gnt_idx;
                        job_op   <= gnt_op;
                        job_data <= gnt_data;
                        rr_ptr   <= rr_next;
                        res_data <= '0;
                        res_err  <= gnt_reject;
                        state    <= gnt_reject ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    if (issue_fire) begin
                        state <= WAIT;
                        if (job_op == OP_KEY) begin
                            key_valid <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (done_match) begin
                        res_data <= done_data;
                        res_err  <= 1'b0;
                        state    <= RESP;
                        if (job_op == OP_KEY) begin
                            key_valid <= 1'b1;
                        end
                    end else if (tmo_next == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                        state    <= RESP;
                        if (job_op == OP_KEY) begin
                            key_valid <= 1'b0;
                        end
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = (state == RESP);
    assign rsp_id_o    = job_id;
    assign rsp_data_o  = res_data;
    assign rsp_err_o   = res_err;
    assign key_valid_o = key_valid;
    assign aes_data_o  = job_data;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a small behavioural AES core
// that answers from known FIPS-197 vectors and emits stray done pulses.
module tb_aes_job_scheduler;

    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] JUNK = 128'hbadbadbadbadbadbadbadbadbadbad00;
    localparam logic [1:0] OP_KEY = 2'b00;
    localparam logic [1:0] OP_ENC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [7:0]   req_op = '0;
    logic [511:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         key_valid;
    logic         set_key, encrypt, decrypt;
    logic [127:0] aes_data;
    logic         set_key_en = 1'b1;
    logic         gen_done = 1'b0, enc_done = 1'b0, dec_done = 1'b0;
    logic [127:0] ct_in = '0, pt_in = '0;

    aes_job_scheduler #(
        .NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_data_i(req_data),
        .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .key_valid_o(key_valid),
        .aes_set_key_o(set_key), .aes_encrypt_o(encrypt),
        .aes_decrypt_o(decrypt), .aes_data_o(aes_data),
        .aes_set_key_enable_i(set_key_en),
        .aes_gen_key_done_i(gen_done),
        .aes_encrypt_done_i(enc_done),
        .aes_decrypt_done_i(dec_done),
        .aes_ciphertext_i(ct_in), .aes_plaintext_i(pt_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int pulses = 0;
    int multi = 0;
    int pulse_cyc = 0;
    int rsp_cyc = 0;
    int pend = -1;
    int dly = 0;
    bit suppress = 1'b0;
    logic [127:0] pend_data = '0;
    logic [1:0]   got_id;
    logic         got_err;
    logic [127:0] got_data;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] enc_f(input logic [127:0] d);
        return (d == PT) ? CT : ~d;
    endfunction

    function automatic logic [127:0] dec_f(input logic [127:0] d);
        return (d == CT) ? PT : ~d;
    endfunction

    // Core model: done three cycles after the pulse, with a wrong-kind done
    // one cycle earlier that the scheduler must ignore.
    always @(negedge clk) begin
        gen_done = 1'b0;
        enc_done = 1'b0;
        dec_done = 1'b0;
        if (!rst_n) begin
            pend = -1;
        end else if (pend >= 0) begin
            if (dly == 0) begin
                case (pend)
                    0: gen_done = 1'b1;
                    1: begin ct_in = enc_f(pend_data); enc_done = 1'b1; end
                    default: begin pt_in = dec_f(pend_data); dec_done = 1'b1; end
                endcase
                pend = -1;
            end else begin
                if (dly == 1) begin
                    ct_in = JUNK;
                    pt_in = JUNK;
                    case (pend)
                        0: enc_done = 1'b1;
                        1: dec_done = 1'b1;
                        default: gen_done = 1'b1;
                    endcase
                end
                dly = dly - 1;
            end
        end
        if (int'(set_key) + int'(encrypt) + int'(decrypt) > 1) multi++;
        if (rst_n && (set_key || encrypt || decrypt)) begin
            pulses++;
            pulse_cyc = cyc;
            if (!suppress) begin
                pend = set_key ? 0 : (encrypt ? 1 : 2);
                dly = 2;
                pend_data = aes_data;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic bound_fail(input string name);
        checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic issue_req(input logic [1:0] r, input logic [1:0] op,
                             input logic [127:0] d);
        int n;
        @(negedge clk);
        req_op[r*2 +: 2] = op;
        req_data[r*128 +: 128] = d;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) bound_fail("grant_wait");
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input bit ack);
        int n;
        n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) bound_fail("rsp_wait");
        rsp_cyc = cyc;
        got_id = rsp_id;
        got_err = rsp_err;
        got_data = rsp_data;
        if (ack) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0]   r;
        logic [1:0]   op;
        logic [127:0] d;
        logic         err;
        logic [127:0] rd;
        int           np;
        logic         kv;
    } vec_t;

    vec_t vt[8];

    initial begin
        int p0;
        int hold_ok;
        int nogrant_ok;
        int late;
        logic [1:0] exp_order[6];

        vt[0] = '{2'd1, OP_ENC, PT, 1'b1, 128'h0, 0, 1'b0};
        vt[1] = '{2'd3, OP_ILL, 128'h0, 1'b1, 128'h0, 0, 1'b0};
        vt[2] = '{2'd0, OP_KEY, KEY, 1'b0, 128'h0, 1, 1'b1};
        vt[3] = '{2'd2, OP_ENC, PT, 1'b0, CT, 1, 1'b1};
        vt[4] = '{2'd1, OP_DEC, CT, 1'b0, PT, 1, 1'b1};
        vt[5] = '{2'd0, OP_ENC, 128'h0, 1'b0, ~128'h0, 1, 1'b1};
        vt[6] = '{2'd2, OP_DEC, 128'h0123456789abcdef0123456789abcdef,
                  1'b0, 128'hfedcba9876543210fedcba9876543210, 1, 1'b1};
        vt[7] = '{2'd3, OP_ILL, PT, 1'b1, 128'h0, 0, 1'b1};
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (3) @(negedge clk);
        check("reset_outputs", 128'(|{req_ready, rsp_valid, rsp_id, rsp_data,
              rsp_err, key_valid, set_key, encrypt, decrypt, aes_data}), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_key_valid", 128'(key_valid), 128'h0);

        for (int i = 0; i < 8; i++) begin
            p0 = pulses;
            issue_req(vt[i].r, vt[i].op, vt[i].d);
            wait_rsp(1'b1);
            check($sformatf("v%0d_id", i), 128'(got_id), 128'(vt[i].r));
            check($sformatf("v%0d_err", i), 128'(got_err), 128'(vt[i].err));
            check($sformatf("v%0d_data", i), got_data, vt[i].rd);
            check($sformatf("v%0d_pulses", i), 128'(pulses - p0), 128'(vt[i].np));
            check($sformatf("v%0d_key_valid", i), 128'(key_valid), 128'(vt[i].kv));
        end

        // All four requesters contend; grants must rotate from requester 0.
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            req_op[r*2 +: 2] = OP_ENC;
            req_data[r*128 +: 128] = PT;
        end
        req_valid = 4'hf;
        #1;
        for (int k = 0; k < 6; k++) begin
            int n;
            n = 0;
            while (req_ready == 4'h0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) bound_fail("rr_wait");
            check($sformatf("rr_grant%0d", k), 128'(req_ready),
                  128'(4'b0001 << exp_order[k]));
            @(posedge clk);
            #1;
            if (k == 5) req_valid = 4'h0;
        end
        repeat (20) @(negedge clk);
        rsp_ready = 1'b0;

        // Backpressure: response held, competing request not granted.
        issue_req(2'd0, OP_ENC, PT);
        req_op[3:2] = OP_ENC;
        req_valid[1] = 1'b1;
        wait_rsp(1'b0);
        hold_ok = 1;
        nogrant_ok = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!(rsp_valid && rsp_id == 2'd0 && rsp_data == CT && !rsp_err))
                hold_ok = 0;
            if (req_ready != 4'h0) nogrant_ok = 0;
        end
        check("bp_hold_stable", 128'(hold_ok), 128'h1);
        check("bp_no_grant", 128'(nogrant_ok), 128'h1);
        check("bp_data", got_data, CT);
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_released", 128'(rsp_valid), 128'h0);

        // set_key stalls in ISSUE until the core enables it.
        set_key_en = 1'b0;
        p0 = pulses;
        issue_req(2'd0, OP_KEY, KEY);
        repeat (6) @(negedge clk);
        check("stall_no_pulse", 128'(pulses - p0), 128'h0);
        set_key_en = 1'b1;
        wait_rsp(1'b1);
        check("stall_pulses", 128'(pulses - p0), 128'h1);
        check("stall_err", 128'(got_err), 128'h0);
        check("stall_key_valid", 128'(key_valid), 128'h1);

        // Encrypt timeout.
        suppress = 1'b1;
        issue_req(2'd2, OP_ENC, PT);
        wait_rsp(1'b1);
        check("tmo_latency", 128'(rsp_cyc - pulse_cyc), 128'd64);
        check("tmo_err", 128'(got_err), 128'h1);
        check("tmo_data", got_data, 128'h0);
        check("tmo_id", 128'(got_id), 128'd2);

        // set_key timeout drops the key.
        issue_req(2'd0, OP_KEY, KEY);
        wait_rsp(1'b1);
        check("keytmo_err", 128'(got_err), 128'h1);
        check("keytmo_key_valid", 128'(key_valid), 128'h0);
        suppress = 1'b0;

        // Reset during WAIT.
        issue_req(2'd0, OP_KEY, KEY);
        wait_rsp(1'b1);
        check("reload_key_valid", 128'(key_valid), 128'h1);
        suppress = 1'b1;
        issue_req(2'd1, OP_ENC, PT);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 128'(|{req_ready, rsp_valid, rsp_id, rsp_data,
              rsp_err, key_valid, set_key, encrypt, decrypt, aes_data}), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        suppress = 1'b0;
        late = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rsp_valid) late++;
        end
        check("midreset_no_rsp", 128'(late), 128'h0);
        check("midreset_key_valid", 128'(key_valid), 128'h0);
        check("cmd_exclusive", 128'(multi), 128'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
